// File: rtl/radar_pkg.sv
// -----------------------------------------------------------------------------
// radar_pkg
// Shared definitions for the radar receive path: frame-header layout, the
// framer FSM state encoding and the PRI/CPI index widths (also used by the
// timing generator).
// No ports (package).
// -----------------------------------------------------------------------------
package radar_pkg;

    localparam int PRI_NUM_W = 10;
    localparam int CPI_NUM_W = 16;

    localparam logic [5:0] HDR_MARKER = 6'h2A;

    // Header word layout: {num_cpi[15:0], marker[5:0], pri_num[9:0]}
    localparam int HDR_PRI_LSB    = 0;
    localparam int HDR_MARKER_LSB = 10;
    localparam int HDR_CPI_LSB    = 16;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_DELAY   = 2'd1,
        ST_HDR     = 2'd2,
        ST_CAPTURE = 2'd3
    } frm_state_e;

    function automatic logic [31:0] make_header(input logic [CPI_NUM_W-1:0] cpi,
                                                input logic [PRI_NUM_W-1:0] pri);
        logic [31:0] h;
        h = '0;
        h[HDR_CPI_LSB    +: CPI_NUM_W] = cpi;
        h[HDR_MARKER_LSB +: 6]         = HDR_MARKER;
        h[HDR_PRI_LSB    +: PRI_NUM_W] = pri;
        return h;
    endfunction

endpackage

// File: rtl/sync_fifo_fwft.sv
// -----------------------------------------------------------------------------
// sync_fifo_fwft
// Single-clock first-word-fall-through FIFO with synchronous flush.
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset
//   i_flush       empties the FIFO on the next edge (wins over push/pop)
//   i_wr_en       push request; accepted when not full, or full with a pop
//   i_wr_data     push data
//   i_rd_en       pop request; ignored when empty
//   o_rd_data     head entry (valid whenever o_empty is low)
//   o_empty       no entries
//   o_full        DEPTH entries
// -----------------------------------------------------------------------------
module sync_fifo_fwft #(
    parameter int WIDTH = 33,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_flush,
    input  logic             i_wr_en,
    input  logic [WIDTH-1:0] i_wr_data,
    input  logic             i_rd_en,
    output logic [WIDTH-1:0] o_rd_data,
    output logic             o_empty,
    output logic             o_full
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;

    logic w_do_rd;
    logic w_do_wr;

    assign o_empty   = (r_count == '0);
    assign o_full    = (r_count == (AW+1)'(DEPTH));
    assign o_rd_data = r_mem[r_rd_ptr];

    // A push at full is accepted when the same edge frees a slot.
    assign w_do_rd = i_rd_en & ~o_empty;
    assign w_do_wr = i_wr_en & (~o_full | w_do_rd);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_wr) begin
                r_mem[r_wr_ptr] <= i_wr_data;
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            if (w_do_rd) r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_do_wr, w_do_rd})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/pri_sample_framer.sv
// -----------------------------------------------------------------------------
// pri_sample_framer
// Opens a receive window cfg_delay cycles after each PRI rise, captures cfg_len
// ADC samples and emits header + samples (tlast on the final word) through a
// FWFT FIFO that absorbs sink backpressure. The ADC is never stalled; a word
// that finds the FIFO full is dropped and flagged on ovf_err.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   enable                capture enable; low aborts the frame and flushes
//   cpib                  CPI-begin pulse; its rise clears ovf_err
//   pri, pri_num, num_cpi PRI pulse and indices from the timing generator
//   cfg_delay, cfg_len    window delay (cycles) and samples per window
//   adc_data, adc_valid   sample stream
//   m_tdata/tvalid/tready/tlast  output stream
//   ovf_err               sticky drop flag
//   pri_skip              1-cycle pulse: PRI rise ignored while busy
//   busy                  FSM not idle
// Handshake: a word moves on every edge where m_tvalid and m_tready are both
// high; m_tvalid stays high with stable data until that happens.
// -----------------------------------------------------------------------------
module pri_sample_framer
    import radar_pkg::*;
#(
    parameter int DATA_W     = 16,
    parameter int LEN_W      = 12,
    parameter int DLY_W      = 16,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 enable,
    input  logic                 cpib,
    input  logic                 pri,
    input  logic [PRI_NUM_W-1:0] pri_num,
    input  logic [CPI_NUM_W-1:0] num_cpi,
    input  logic [DLY_W-1:0]     cfg_delay,
    input  logic [LEN_W-1:0]     cfg_len,
    input  logic [DATA_W-1:0]    adc_data,
    input  logic                 adc_valid,
    output logic [31:0]          m_tdata,
    output logic                 m_tvalid,
    input  logic                 m_tready,
    output logic                 m_tlast,
    output logic                 ovf_err,
    output logic                 pri_skip,
    output logic                 busy
);
    frm_state_e            r_state;
    logic                  r_pri_q;
    logic                  r_cpib_q;
    logic                  r_en;
    logic [DLY_W-1:0]      r_dly;
    logic [LEN_W-1:0]      r_len;
    logic [LEN_W-1:0]      r_cnt;
    logic [PRI_NUM_W-1:0]  r_pri_num;
    logic [CPI_NUM_W-1:0]  r_num_cpi;
    logic                  r_ovf;
    logic                  r_pri_skip;

    logic                  w_pri_rise;
    logic                  w_cpib_rise;
    logic [LEN_W-1:0]      w_cnt_nxt;
    logic                  w_push;
    logic [32:0]           w_push_word;
    logic                  w_pop;
    logic                  w_drop;
    logic                  w_empty;
    logic                  w_full;
    logic [32:0]           w_head;

    assign w_pri_rise  = pri & ~r_pri_q;
    assign w_cpib_rise = cpib & ~r_cpib_q;
    assign w_cnt_nxt   = r_cnt + LEN_W'(1);

    always_comb begin
        w_push      = 1'b0;
        w_push_word = '0;
        if (enable) begin
            case (r_state)
                ST_HDR: begin
                    w_push      = 1'b1;
                    w_push_word = {(r_len == '0), make_header(r_num_cpi, r_pri_num)};
                end
                ST_CAPTURE: begin
                    w_push      = adc_valid;
                    w_push_word = {(w_cnt_nxt == r_len), {(32-DATA_W){1'b0}}, adc_data};
                end
                default: ;
            endcase
        end
    end

    assign w_pop  = ~w_empty & m_tready;
    assign w_drop = w_push & w_full & ~w_pop;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_pri_q    <= 1'b0;
            r_cpib_q   <= 1'b0;
            r_en       <= 1'b0;
            r_dly      <= '0;
            r_len      <= '0;
            r_cnt      <= '0;
            r_pri_num  <= '0;
            r_num_cpi  <= '0;
            r_ovf      <= 1'b0;
            r_pri_skip <= 1'b0;
        end else begin
            r_pri_q    <= pri;
            r_cpib_q   <= cpib;
            r_en       <= enable;
            r_pri_skip <= w_pri_rise & (r_state != ST_IDLE);

            // A drop in the clearing cycle must remain visible.
            if (w_drop)           r_ovf <= 1'b1;
            else if (w_cpib_rise) r_ovf <= 1'b0;

            if (!enable) begin
                r_state <= ST_IDLE;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        // Registered enable: a rise coinciding with enable rising is ignored.
                        if (w_pri_rise && r_en) begin
                            r_pri_num <= pri_num;
                            r_num_cpi <= num_cpi;
                            r_len     <= cfg_len;
                            r_dly     <= cfg_delay;
                            r_cnt     <= '0;
                            r_state   <= (cfg_delay == '0) ? ST_HDR : ST_DELAY;
                        end
                    end
                    ST_DELAY: begin
                        // Header is pushed cfg_delay+1 edges after the rise edge.
                        if (r_dly == DLY_W'(1)) r_state <= ST_HDR;
                        else                    r_dly   <= r_dly - DLY_W'(1);
                    end
                    ST_HDR: begin
                        r_state <= (r_len == '0) ? ST_IDLE : ST_CAPTURE;
                    end
                    ST_CAPTURE: begin
                        // Dropped samples still count so frame length stays fixed.
                        if (adc_valid) begin
                            r_cnt <= w_cnt_nxt;
                            if (w_cnt_nxt == r_len) r_state <= ST_IDLE;
                        end
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

    sync_fifo_fwft #(
        .WIDTH (33),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_flush   (~enable),
        .i_wr_en   (w_push),
        .i_wr_data (w_push_word),
        .i_rd_en   (m_tready),
        .o_rd_data (w_head),
        .o_empty   (w_empty),
        .o_full    (w_full)
    );

    assign m_tdata  = w_head[31:0];
    assign m_tlast  = w_head[32];
    assign m_tvalid = ~w_empty;
    assign ovf_err  = r_ovf;
    assign pri_skip = r_pri_skip;
    assign busy     = (r_state != ST_IDLE);

endmodule

// File: tb/tb_pri_sample_framer.sv
// -----------------------------------------------------------------------------
// tb_pri_sample_framer
// Scoreboard bench for pri_sample_framer. Expected words (and, where the sink
// never stalls, the cycle each word must appear) are queued when a PRI is
// driven; a monitor pops and compares every accepted output word.
// Cycle numbering: "cycle N" is the value present just before posedge N,
// where posedge 0 is the first edge that samples pri=1.
// -----------------------------------------------------------------------------
module tb_pri_sample_framer;

    logic        clk;
    logic        rst_n;
    logic        enable;
    logic        cpib;
    logic        pri;
    logic [9:0]  pri_num;
    logic [15:0] num_cpi;
    logic [15:0] cfg_delay;
    logic [11:0] cfg_len;
    logic [15:0] adc_data;
    logic        adc_valid;
    logic [31:0] m_tdata;
    logic        m_tvalid;
    logic        m_tready;
    logic        m_tlast;
    logic        ovf_err;
    logic        pri_skip;
    logic        busy;

    int          n_chk  = 0;
    int          n_fail = 0;
    int          cyc    = 0;
    bit          toggle_valid = 1'b0;

    logic [32:0] exp_q[$];
    int          exp_cyc_q[$];

    pri_sample_framer #(
        .DATA_W     (16),
        .LEN_W      (12),
        .DLY_W      (16),
        .FIFO_DEPTH (16)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .enable    (enable),
        .cpib      (cpib),
        .pri       (pri),
        .pri_num   (pri_num),
        .num_cpi   (num_cpi),
        .cfg_delay (cfg_delay),
        .cfg_len   (cfg_len),
        .adc_data  (adc_data),
        .adc_valid (adc_valid),
        .m_tdata   (m_tdata),
        .m_tvalid  (m_tvalid),
        .m_tready  (m_tready),
        .m_tlast   (m_tlast),
        .ovf_err   (ovf_err),
        .pri_skip  (pri_skip),
        .busy      (busy)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- checking ----------------
    task automatic chk(input string tag, input logic [32:0] got, input logic [32:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // ---------------- stimulus helpers ----------------
    function automatic bit valid_at(input int e);
        return toggle_valid ? e[0] : 1'b1;
    endfunction

    function automatic logic [15:0] data_at(input int e);
        return 16'hA000 + e[15:0];
    endfunction

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Drives a PRI rise for the next edge and queues the expected frame.
    // keep < 0 queues every word; otherwise only the first keep words.
    task automatic start_frame(input int dly, input int len, input logic [9:0] pn,
                               input logic [15:0] nc, input bit expect_out,
                               input bit timed, input int keep);
        int t0;
        int e;
        int n;
        int k;
        cfg_delay = dly[15:0];
        cfg_len   = len[11:0];
        pri_num   = pn;
        num_cpi   = nc;
        pri       = 1'b1;
        t0        = cyc;
        if (expect_out) begin
            exp_q.push_back({(len == 0), nc, 6'h2A, pn});
            exp_cyc_q.push_back(timed ? t0 + dly + 2 : -1);
            k = 1;
            e = t0 + dly + 2;
            n = 0;
            while (n < len) begin
                if (valid_at(e)) begin
                    if (keep < 0 || k < keep) begin
                        exp_q.push_back({(n + 1 == len), 16'h0000, data_at(e)});
                        exp_cyc_q.push_back(timed ? e + 1 : -1);
                        k++;
                    end
                    n++;
                end
                e++;
            end
        end
    endtask

    task automatic wait_idle(input int max_cyc);
        int i;
        i = 0;
        step(1);
        while ((exp_q.size() != 0 || busy) && i < max_cyc) begin
            step(1);
            i++;
        end
        chk("words_outstanding", exp_q.size(), 0);
        chk("busy_after_frame", busy, 1'b0);
    endtask

    task automatic wait_not_busy(input int max_cyc);
        int i;
        i = 0;
        while (busy && i < max_cyc) begin
            step(1);
            i++;
        end
        chk("busy_timeout", busy, 1'b0);
    endtask

    // ---------------- ADC driver ----------------
    initial begin
        adc_data  = '0;
        adc_valid = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            adc_data  = data_at(cyc);
            adc_valid = valid_at(cyc);
        end
    end

    // ---------------- scoreboard monitor ----------------
    initial begin
        logic [32:0] w;
        int          c;
        forever begin
            @(negedge clk);
            if (rst_n && m_tvalid && m_tready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_word_queue_size", exp_q.size(), 1);
                end else begin
                    w = exp_q.pop_front();
                    c = exp_cyc_q.pop_front();
                    chk("word", {m_tlast, m_tdata}, w);
                    if (c >= 0) chk("word_cycle", cyc, c);
                end
            end
        end
    end

    // ---------------- main sequence ----------------
    initial begin
        int dly;
        int len;
        rst_n     = 1'b0;
        enable    = 1'b0;
        cpib      = 1'b0;
        pri       = 1'b0;
        pri_num   = '0;
        num_cpi   = '0;
        cfg_delay = '0;
        cfg_len   = '0;
        m_tready  = 1'b1;
        step(3);

        chk("rst_tvalid", m_tvalid, 1'b0);
        chk("rst_tlast", m_tlast, 1'b0);
        chk("rst_tdata", m_tdata, 32'h0);
        chk("rst_ovf", ovf_err, 1'b0);
        chk("rst_pri_skip", pri_skip, 1'b0);
        chk("rst_busy", busy, 1'b0);

        rst_n  = 1'b1;
        enable = 1'b1;
        step(2);

        // Basic frame: header at cycle 7, samples 8..11.
        start_frame(5, 4, 10'h155, 16'h1234, 1'b1, 1'b1, -1);
        step(2);
        pri = 1'b0;
        wait_idle(60);

        // Zero-length, zero-delay frame: busy only in cycle 1.
        start_frame(0, 0, 10'h03C, 16'h0001, 1'b1, 1'b1, -1);
        step(1);
        chk("len0_busy_c1", busy, 1'b1);
        step(1);
        chk("len0_busy_c2", busy, 1'b0);
        pri = 1'b0;
        wait_idle(20);

        // Random short frames.
        for (int r = 0; r < 3; r++) begin
            dly = $urandom_range(0, 6);
            len = $urandom_range(1, 6);
            start_frame(dly, len, 10'(r + 7), 16'(16'h0100 + r), 1'b1, 1'b1, -1);
            step(2);
            pri = 1'b0;
            wait_idle(60);
        end

        // Second PRI rise during CAPTURE is skipped.
        start_frame(2, 8, 10'h2AA, 16'h00F0, 1'b1, 1'b1, -1);
        step(2);
        pri = 1'b0;
        step(3);
        pri       = 1'b1;
        pri_num   = 10'h001;
        cfg_len   = 12'd3;
        cfg_delay = 16'd0;
        step(1);
        chk("skip_pulse", pri_skip, 1'b1);
        step(1);
        chk("skip_one_cycle", pri_skip, 1'b0);
        pri = 1'b0;
        wait_idle(60);

        // Backpressure overflow: 16 words held, 5 dropped.
        m_tready = 1'b0;
        start_frame(2, 20, 10'h0AB, 16'h0777, 1'b1, 1'b0, 16);
        step(2);
        pri = 1'b0;
        wait_not_busy(60);
        step(2);
        chk("ovf_set", ovf_err, 1'b1);
        chk("ovf_tvalid_held", m_tvalid, 1'b1);
        m_tready = 1'b1;
        wait_idle(60);
        chk("ovf_drained_tvalid", m_tvalid, 1'b0);
        chk("ovf_sticky", ovf_err, 1'b1);

        // Enable low mid-CAPTURE aborts and flushes.
        m_tready = 1'b0;
        start_frame(1, 10, 10'h011, 16'h0222, 1'b0, 1'b0, -1);
        step(2);
        pri = 1'b0;
        step(3);
        chk("abort_pre_busy", busy, 1'b1);
        enable = 1'b0;
        step(1);
        chk("abort_tvalid", m_tvalid, 1'b0);
        chk("abort_busy", busy, 1'b0);
        chk("abort_keeps_ovf", ovf_err, 1'b1);
        step(2);
        chk("abort_tvalid_later", m_tvalid, 1'b0);
        m_tready = 1'b1;
        // PRI rise coinciding with enable rise is ignored.
        enable = 1'b1;
        pri    = 1'b1;
        step(3);
        chk("en_rise_pri_ignored", busy, 1'b0);
        chk("en_rise_no_output", m_tvalid, 1'b0);
        pri = 1'b0;
        step(2);
        start_frame(3, 5, 10'h3FF, 16'hBEEF, 1'b1, 1'b1, -1);
        step(2);
        pri = 1'b0;
        wait_idle(60);

        // cpib rise clears ovf_err.
        cpib = 1'b1;
        step(1);
        chk("cpib_clears_ovf", ovf_err, 1'b0);
        cpib = 1'b0;
        step(1);
        chk("ovf_stays_clear", ovf_err, 1'b0);

        // Toggling adc_valid, cfg_len changed mid-frame.
        toggle_valid = 1'b1;
        step(2);
        start_frame(2, 3, 10'h0C3, 16'h5A5A, 1'b1, 1'b1, -1);
        step(1);
        cfg_len = 12'd9;
        step(1);
        pri = 1'b0;
        wait_idle(60);
        toggle_valid = 1'b0;
        step(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
